// File: rtl/neuron_seq_trainer.sv
// neuron_seq_trainer: time-multiplexed trainable neuron, signed Q(BITS-FRAC).FRAC.
// Forward pass: one shared multiplier accumulates x*w over N cycles, then activation.
// Backward pass: SGD update of one weight per cycle, then the bias.
// Optional macro NEURON_SAT_EN: saturating arithmetic; when undefined, results wrap.
module neuron_seq_trainer #(
    parameter int N    = 6,
    parameter int BITS = 16,
    parameter int FRAC = 8,
    parameter int ACT  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N*BITS-1:0]     x,
    input  logic                  load_w,
    input  logic [N*BITS-1:0]     w_init,
    input  logic [BITS-1:0]       b_init,
    input  logic                  start,
    input  logic                  upd,
    input  logic [BITS-1:0]       dz_in,
    input  logic [BITS-1:0]       lr,
    output logic                  busy,
    output logic                  done,
    output logic [BITS-1:0]       y,
    output logic [BITS-1:0]       z,
    output logic [(N+1)*BITS-1:0] w_out
);
    localparam int AW = 2*BITS + $clog2(N+1);
    localparam int SW = AW + 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic signed [BITS+1:0] HALF = (BITS+2)'(1) << (FRAC-1);
    localparam logic signed [BITS+1:0] ONE  = (BITS+2)'(1) << FRAC;

    typedef enum logic [2:0] {S_IDLE, S_MAC, S_ACT, S_UPD, S_BIAS, S_DONE} state_t;

    state_t                 r_state, w_next;
    logic [N-1:0][BITS-1:0] r_w, r_x;
    logic signed [BITS-1:0] r_b, r_g, r_y, r_z;
    logic signed [AW-1:0]   r_acc;
    logic [IW-1:0]          r_idx;

    logic signed [BITS-1:0]   w_xi, w_wi, w_zsat, w_act, w_dz_eff, w_g, w_wnew, w_bnew;
    logic signed [2*BITS-1:0] w_prod, w_gprod, w_dprod;
    logic signed [BITS+1:0]   w_hs;
    logic                     w_last;

    // Narrow a wide intermediate to BITS: clamp when saturation is built in, else wrap.
    function automatic logic signed [BITS-1:0] sat(input logic signed [SW-1:0] v);
`ifdef NEURON_SAT_EN
        logic signed [SW-1:0] vmax, vmin;
        vmax = {{(SW-BITS+1){1'b0}}, {(BITS-1){1'b1}}};
        vmin = {{(SW-BITS+1){1'b1}}, {(BITS-1){1'b0}}};
        if (v > vmax)      return vmax[BITS-1:0];
        else if (v < vmin) return vmin[BITS-1:0];
        else               return v[BITS-1:0];
`else
        return v[BITS-1:0];
`endif
    endfunction

    // Shared arithmetic: MAC product, activation, gradient and per-weight update values.
    always_comb begin
        w_xi     = $signed(r_x[r_idx]);
        w_wi     = $signed(r_w[r_idx]);
        w_last   = (r_idx == IW'(N-1));
        w_prod   = (2*BITS)'(w_xi) * (2*BITS)'(w_wi);
        w_zsat   = sat(SW'(r_acc >>> FRAC));
        w_hs     = HALF + (BITS+2)'(w_zsat >>> 2);
        w_act    = '0;
        w_dz_eff = '0;
        if (ACT == 0) begin
            w_act = w_zsat[BITS-1] ? '0 : w_zsat;
            if (!r_z[BITS-1] && (r_z != '0))
                w_dz_eff = $signed(dz_in);
        end else begin
            if (w_hs[BITS+1])  w_act = '0;
            else if (w_hs > ONE) w_act = ONE[BITS-1:0];
            else               w_act = w_hs[BITS-1:0];
            // Gradient flows only in the linear region of the hard sigmoid.
            if (!r_y[BITS-1] && (r_y != '0) && ((BITS+2)'(r_y) < ONE))
                w_dz_eff = $signed(dz_in) >>> 2;
        end
        w_gprod = (2*BITS)'(w_dz_eff) * (2*BITS)'($signed(lr));
        w_g     = sat(SW'(w_gprod >>> FRAC));
        w_dprod = (2*BITS)'(r_g) * (2*BITS)'(w_xi);
        w_wnew  = sat(SW'(w_wi) - SW'(w_dprod >>> FRAC));
        w_bnew  = sat(SW'(r_b) - SW'(r_g));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next state and status outputs; IDLE arbitrates load_w > start > upd.
    always_comb begin
        w_next = r_state;
        busy   = (r_state != S_IDLE);
        done   = (r_state == S_DONE);
        case (r_state)
            S_IDLE: begin
                if (load_w)     w_next = S_IDLE;
                else if (start) w_next = S_MAC;
                else if (upd)   w_next = S_UPD;
            end
            S_MAC:   if (w_last) w_next = S_ACT;
            S_ACT:   w_next = S_DONE;
            S_UPD:   if (w_last) w_next = S_BIAS;
            S_BIAS:  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath registers: weight store, latched inputs, accumulator, results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w   <= '0;
            r_x   <= '0;
            r_b   <= '0;
            r_g   <= '0;
            r_y   <= '0;
            r_z   <= '0;
            r_acc <= '0;
            r_idx <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (load_w) begin
                        r_w <= w_init;
                        r_b <= b_init;
                    end else if (start) begin
                        r_x   <= x;
                        r_acc <= AW'(r_b) <<< FRAC;
                        r_idx <= '0;
                    end else if (upd) begin
                        r_g   <= w_g;
                        r_idx <= '0;
                    end
                end
                S_MAC: begin
                    r_acc <= r_acc + AW'(w_prod);
                    r_idx <= r_idx + IW'(1);
                end
                S_ACT: begin
                    r_z <= w_zsat;
                    r_y <= w_act;
                end
                S_UPD: begin
                    r_w[r_idx] <= w_wnew;
                    r_idx      <= r_idx + IW'(1);
                end
                S_BIAS:  r_b <= w_bnew;
                default: ;
            endcase
        end
    end

    assign y     = r_y;
    assign z     = r_z;
    assign w_out = {r_b, r_w};
endmodule

// File: doc/neuron_seq_trainer.md
Name: neuron_seq_trainer

Overview:
- Time-multiplexed, trainable single neuron in signed fixed-point; a parametrised successor to the combinational Neuron_ReLU/Neuron_Sigmoid pair.
- Holds its own weights and bias. Forward pass uses one shared multiplier over N cycles; backward pass performs an SGD update one weight per cycle.
- Driven by the layer controller (the ArchCTRL FP/BP phase strobes) through start/upd pulses.
- Activation (ReLU or hard sigmoid) is chosen by parameter.

Parameters:
- N, 6, number of inputs/weights (>=1).
- BITS, 16, data width, two's complement.
- FRAC, 8, fractional bits (Q(BITS-FRAC).FRAC; default Q8.8).
- ACT, 0, activation: 0 = ReLU, 1 = hard sigmoid.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- x  in  N*BITS  input vector, element i at [i*BITS +: BITS]
- load_w  in  1  pulse: load w_init/b_init into weight store
- w_init  in  N*BITS  initial weights
- b_init  in  BITS  initial bias
- start  in  1  pulse: begin forward pass
- upd  in  1  pulse: begin backward/update pass
- dz_in  in  BITS  upstream gradient dL/dy
- lr  in  BITS  learning rate (signed)
- busy  out  1  high while FSM is not IDLE
- done  out  1  one-cycle pulse at end of either pass
- y  out  BITS  activated output
- z  out  BITS  pre-activation sum
- w_out  out  (N+1)*BITS  {bias at slot N, w[N-1..0]}, live register view

Behaviour:
- Reset (async, rst_n=0):
  - FSM=IDLE; busy=0, done=0.
  - y, z, all weights, bias, latched x, accumulator and index counter clear to 0.
  - Reset asserted mid-pass aborts the pass; no partial result is retained.
- FSM states: IDLE, MAC, ACT, UPD, BIAS, DONE.
- IDLE command priority: load_w > start > upd. Lower-priority commands in the same cycle are dropped.
  - load_w: takes 1 cycle; stays in IDLE; weights and bias are visible on w_out the next cycle; no done pulse.
- Commands arriving while busy=1 are ignored, not queued.
- Forward pass:
  - start: latch x into x_r, clear accumulator to sign-extended bias (scaled by 2^FRAC), idx=0, go to MAC.
  - MAC: acc += x_r[idx]*w[idx] (full 2*BITS product, accumulator 2*BITS+clog2(N+1) wide); idx++. Leave after idx==N-1.
  - ACT:
    - z = acc >>> FRAC, saturated to BITS.
    - ReLU: y = z<0 ? 0 : z.
    - Hard sigmoid: y = clamp((1<<(FRAC-1)) + (z>>>2), 0, 1<<FRAC).
  - DONE: done=1 for one cycle, then IDLE. Latency start->done = N+2 cycles; y and z are valid when done is high and held until the next ACT or reset.
- Backward pass:
  - upd: compute dz_eff from the held z.
    - ReLU: z>0 ? dz_in : 0.
    - Sigmoid: 0 < y < 1<<FRAC ? dz_in>>>2 : 0.
  - g = sat((dz_eff*lr) >>> FRAC). Latch g, idx=0, go to UPD.
  - UPD: w[idx] = sat(w[idx] - ((g*x_r[idx]) >>> FRAC)); one weight per cycle, N cycles.
  - BIAS: b = sat(b - g). Then DONE. Latency upd->done = N+2 cycles.
  - upd without a prior forward pass uses x_r=0 and z=0. ReLU then gives dz_eff=0, so there is no change.
- Rounding: arithmetic right shift (floor) everywhere. sat() clamps to [-2^(BITS-1), 2^(BITS-1)-1].

Optional Feature:
- Macro: NEURON_SAT_EN.
- Defined: every sat() above clamps as specified.
- Undefined: sat() truncates to the low BITS bits (wrap-around); saves comparators.
- Activation clamps are present in both builds.

Test Plan:
- Forward, ReLU:
  - Stimulus: load_w with all w=0x0100, b=0; x0=0x0100, x1=0x0200, rest 0; start.
  - Expect: busy for N+2 cycles; done at cycle 8; z=y=0x0300.
- Forward, negative input:
  - Stimulus: x0=0xFE00, rest 0, same weights.
  - Expect: ReLU gives z=0xFE00, y=0. ACT=1 with x0=0x0100 gives y=0x00C0.
- Update after the ReLU forward pass above:
  - Stimulus: upd with dz_in=0x0100, lr=0x0080.
  - Expect: w0=0x0080, w1=0x0000, w2..5=0x0100, b=0xFF80; done N+2 cycles after upd.
- Saturation:
  - Stimulus: all w=0x7FFF, x=0x7FFF, start.
  - Expect: with NEURON_SAT_EN, z=0x7FFF; without it, z equals the low 16 bits of the true sum.
- Reset mid-MAC:
  - Stimulus: drop rst_n at cycle 3 of MAC.
  - Expect: immediately busy=0, done=0, y=z=0, w_out all 0. A new start after release runs normally.
- Command arbitration:
  - Stimulus: start while busy; start+upd in the same IDLE cycle; load_w+start in the same cycle.
  - Expect: start while busy is ignored; start+upd runs only the forward pass; load_w+start performs the load only and stays IDLE.
